i2c_txn_arbiter: RTL

- Shares one I2C_master instance between N_REQ on-chip requesters.
- Each requester posts a single-byte read or write command. The block grants one requester at a time in round-robin order and sequences the master's start_txn/done handshake. It then returns read data and status to the granted requester.
- A watchdog terminates the wait if the master never reports done.
- Sits between requester logic (sensor pollers, config loaders) and I2C_master.

---
 rtl/i2c_txn_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters.
// Sequences start_txn/done per single-byte command, with a done watchdog.
module i2c_txn_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               rsp_ack_error,
  output logic               rsp_timeout,
  output logic               m_start_txn,
  output logic               m_rw,
  output logic [6:0]         m_sub_addr,
  output logic [7:0]         m_data_in,
  output logic               m_data_valid,
  output logic               m_next_byte,
  input  logic               m_busy,
  input  logic               m_done,
  input  logic               m_ack_error,
  input  logic [7:0]         m_data_out,
  input  logic               m_data_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   gnt_idx_reg, gnt_idx_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic               cmd_rw_reg, cmd_rw_next;
  logic [6:0]         cmd_addr_reg, cmd_addr_next;
  logic [7:0]         cmd_wdata_reg, cmd_wdata_next;
  logic [7:0]         rdata_reg, rdata_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [N_REQ-1:0]   rsp_valid_reg, rsp_valid_next;
  logic [7:0]         rsp_rdata_reg, rsp_rdata_next;
  logic               rsp_ack_error_reg, rsp_ack_error_next;
  logic               rsp_timeout_reg, rsp_timeout_next;
  logic               m_start_txn_reg, m_start_txn_next;
  logic               m_rw_reg, m_rw_next;
  logic [6:0]         m_sub_addr_reg, m_sub_addr_next;
  logic [7:0]         m_data_in_reg, m_data_in_next;
  logic               m_data_valid_reg, m_data_valid_next;

  logic [6:0]         addr_arr  [N_REQ];
  logic [7:0]         wdata_arr [N_REQ];
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [7:0]         rdata_eff;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[7*gi +: 7];
      assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  // First requesting index at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  // A byte arriving together with done must still reach the response.
  assign rdata_eff = m_data_ready ? m_data_out : rdata_reg;

  always_comb begin
    state_next         = state_reg;
    rr_ptr_next        = rr_ptr_reg;
    gnt_idx_next       = gnt_idx_reg;
    timer_next         = timer_reg;
    cmd_rw_next        = cmd_rw_reg;
    cmd_addr_next      = cmd_addr_reg;
    cmd_wdata_next     = cmd_wdata_reg;
    rdata_next         = rdata_reg;
    grant_next         = grant_reg;
    rsp_valid_next     = '0;
    rsp_rdata_next     = rsp_rdata_reg;
    rsp_ack_error_next = rsp_ack_error_reg;
    rsp_timeout_next   = rsp_timeout_reg;
    m_start_txn_next   = 1'b0;
    m_rw_next          = m_rw_reg;
    m_sub_addr_next    = m_sub_addr_reg;
    m_data_in_next     = m_data_in_reg;
    m_data_valid_next  = m_data_valid_reg;

    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          gnt_idx_next        = sel_idx;
          cmd_rw_next         = req_rw[sel_idx];
          cmd_addr_next       = addr_arr[sel_idx];
          cmd_wdata_next      = wdata_arr[sel_idx];
          grant_next          = '0;
          grant_next[sel_idx] = 1'b1;
          state_next          = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_busy) begin
          m_start_txn_next  = 1'b1;
          m_rw_next         = cmd_rw_reg;
          m_sub_addr_next   = cmd_addr_reg;
          m_data_in_next    = cmd_wdata_reg;
          m_data_valid_next = !cmd_rw_reg;
          timer_next        = '0;
          rdata_next        = 8'h00;
          state_next        = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (m_data_ready) rdata_next = m_data_out;
        // Response registers load on the exit edge so rsp_valid follows done by one cycle.
        if (m_done || (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1))) begin
          rsp_valid_next     = grant_reg;
          rsp_rdata_next     = cmd_rw_reg ? rdata_eff : 8'h00;
          rsp_ack_error_next = m_done ? m_ack_error : 1'b0;
          rsp_timeout_next   = !m_done;
          m_data_valid_next  = 1'b0;
          state_next         = RESPOND;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      RESPOND: begin
        grant_next  = '0;
        rr_ptr_next = (gnt_idx_reg == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_reg + IDX_W'(1);
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      rr_ptr_reg        <= '0;
      gnt_idx_reg       <= '0;
      timer_reg         <= '0;
      cmd_rw_reg        <= 1'b0;
      cmd_addr_reg      <= '0;
      cmd_wdata_reg     <= '0;
      rdata_reg         <= '0;
      grant_reg         <= '0;
      rsp_valid_reg     <= '0;
      rsp_rdata_reg     <= '0;
      rsp_ack_error_reg <= 1'b0;
      rsp_timeout_reg   <= 1'b0;
      m_start_txn_reg   <= 1'b0;
      m_rw_reg          <= 1'b0;
      m_sub_addr_reg    <= '0;
      m_data_in_reg     <= '0;
      m_data_valid_reg  <= 1'b0;
    end else begin
      state_reg         <= state_next;
      rr_ptr_reg        <= rr_ptr_next;
      gnt_idx_reg       <= gnt_idx_next;
      timer_reg         <= timer_next;
      cmd_rw_reg        <= cmd_rw_next;
      cmd_addr_reg      <= cmd_addr_next;
      cmd_wdata_reg     <= cmd_wdata_next;
      rdata_reg         <= rdata_next;
      grant_reg         <= grant_next;
      rsp_valid_reg     <= rsp_valid_next;
      rsp_rdata_reg     <= rsp_rdata_next;
      rsp_ack_error_reg <= rsp_ack_error_next;
      rsp_timeout_reg   <= rsp_timeout_next;
      m_start_txn_reg   <= m_start_txn_next;
      m_rw_reg          <= m_rw_next;
      m_sub_addr_reg    <= m_sub_addr_next;
      m_data_in_reg     <= m_data_in_next;
      m_data_valid_reg  <= m_data_valid_next;
    end
  end

  assign grant         = grant_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_ack_error = rsp_ack_error_reg;
  assign rsp_timeout   = rsp_timeout_reg;
  assign m_start_txn   = m_start_txn_reg;
  assign m_rw          = m_rw_reg;
  assign m_sub_addr    = m_sub_addr_reg;
  assign m_data_in     = m_data_in_reg;
  assign m_data_valid  = m_data_valid_reg;
  assign m_next_byte   = 1'b0;

endmodule
